// File: rtl/pl_run_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : plctrl_pkg
// Brief    : Shared encodings for the pipeline run-control sequencer: FSM
//            states, command opcodes and halt-cause codes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package plctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STEP  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam logic [1:0] c_OP_RUN    = 2'b00;
   localparam logic [1:0] c_OP_HALT   = 2'b01;
   localparam logic [1:0] c_OP_STEP   = 2'b10;
   localparam logic [1:0] c_OP_CLRCNT = 2'b11;

   localparam logic [1:0] c_CAUSE_NONE = 2'd0;
   localparam logic [1:0] c_CAUSE_CMD  = 2'd1;
   localparam logic [1:0] c_CAUSE_BP   = 2'd2;
   localparam logic [1:0] c_CAUSE_STEP = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pl_run_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pl_run_ctrl_if
// Brief    : Command handshake between a debug/bench requester (master) and
//            the run-control sequencer (slave).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface pl_run_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_steps;

   modport master (output cmd_valid, output cmd_op, output cmd_steps, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_steps, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/pl_run_ctrl_perf_cnt.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pl_perf_cnt
// Brief    : Cycle and retired-instruction counters with synchronous clear.
//            Built only when PLCTRL_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pl_perf_cnt #(
   parameter int CNTW = 32
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            clr,
   input  wire logic            cyc_inc,
   input  wire logic            ret_inc,
   output logic [CNTW-1:0]      cycle_cnt,
   output logic [CNTW-1:0]      instret
);

   logic [CNTW-1:0] r_cycle_cnt;
   logic [CNTW-1:0] r_instret;

   // Clear beats a same-cycle increment; both counters wrap silently.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cycle_cnt <= '0;
         r_instret   <= '0;
      end else begin
         if (cyc_inc) r_cycle_cnt <= r_cycle_cnt + 1'b1;
         if (ret_inc) r_instret   <= r_instret + 1'b1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
   assign instret   = r_instret;

endmodule
`default_nettype wire

// File: rtl/pl_run_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pl_run_ctrl
// Brief    : Run-control sequencer: gates fetch for run / halt / single- and
//            multi-step / PC breakpoint, drains the pipe before reporting
//            halted. Optional counters under macro PLCTRL_PERF_CNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pl_run_ctrl
   import plctrl_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int CNTW     = 32,
   parameter bit BOOT_RUN = 1'b1
) (
   input  wire logic            clk,
   input  wire logic            rstn,        // active-high synchronous reset
   pl_run_ctrl_if.slave         cmd,
   input  wire logic [XLEN-1:0] if_pc,
   input  wire logic            pipe_hold,
   input  wire logic            retire,
   input  wire logic            pipe_empty,
   input  wire logic            bp_en,
   input  wire logic [XLEN-1:0] bp_addr,
   output logic                 fetch_stall,
   output logic                 halted,
   output logic [1:0]           run_state,
   output logic [1:0]           halt_cause,
   output logic [CNTW-1:0]      cycle_cnt,
   output logic [CNTW-1:0]      instret
);

   localparam state_t c_BOOT_STATE = BOOT_RUN ? ST_RUN : ST_HALT;

   state_t     r_state,    w_state_nxt;
   logic [7:0] r_step_cnt, w_step_cnt_nxt;
   logic [1:0] r_cause,    w_cause_nxt;
   logic       r_bp_skip,  w_bp_skip_nxt;
   logic       r_halted;

   logic w_active, w_bp_hit, w_fetch_fire, w_cmd_acc, w_clr;

   assign w_active     = (r_state == ST_RUN) || (r_state == ST_STEP);
   assign w_bp_hit     = bp_en && (if_pc == bp_addr) && !r_bp_skip && w_active;
   assign fetch_stall  = !w_active || w_bp_hit;
   assign w_fetch_fire = !fetch_stall && !pipe_hold && w_active;
   assign cmd.cmd_ready = (r_state == ST_RUN) || (r_state == ST_HALT);
   assign w_cmd_acc    = cmd.cmd_valid && cmd.cmd_ready;
   assign w_clr        = w_cmd_acc && (cmd.cmd_op == c_OP_CLRCNT);

   // Next-state, step count, halt cause and breakpoint-skip decisions.
   always_comb begin
      w_state_nxt    = r_state;
      w_step_cnt_nxt = r_step_cnt;
      w_cause_nxt    = r_cause;
      w_bp_skip_nxt  = r_bp_skip;
      // The first instruction fetched after resuming consumes the skip.
      if (w_fetch_fire) w_bp_skip_nxt = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_bp_hit) begin
               w_state_nxt = ST_DRAIN;
               w_cause_nxt = c_CAUSE_BP;
            end else if (w_cmd_acc && (cmd.cmd_op == c_OP_HALT)) begin
               w_state_nxt = ST_DRAIN;
               w_cause_nxt = c_CAUSE_CMD;
            end
         end
         ST_STEP: begin
            if (w_bp_hit) begin
               w_state_nxt    = ST_DRAIN;
               w_cause_nxt    = c_CAUSE_BP;
               w_step_cnt_nxt = 8'd0;
            end else if (w_fetch_fire) begin
               w_step_cnt_nxt = r_step_cnt - 8'd1;
               if (r_step_cnt == 8'd1) begin
                  w_state_nxt = ST_DRAIN;
                  w_cause_nxt = c_CAUSE_STEP;
               end
            end
         end
         ST_DRAIN: begin
            if (pipe_empty) w_state_nxt = ST_HALT;
         end
         ST_HALT: begin
            if (w_cmd_acc && (cmd.cmd_op == c_OP_RUN)) begin
               w_state_nxt   = ST_RUN;
               w_cause_nxt   = c_CAUSE_NONE;
               w_bp_skip_nxt = 1'b1;
            end else if (w_cmd_acc && (cmd.cmd_op == c_OP_STEP)) begin
               w_state_nxt    = ST_STEP;
               w_step_cnt_nxt = (cmd.cmd_steps == 8'd0) ? 8'd1 : cmd.cmd_steps;
               w_bp_skip_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = c_BOOT_STATE;
      endcase
   end

   // State register; halted tracks the registered state exactly.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_state    <= c_BOOT_STATE;
         r_step_cnt <= 8'd0;
         r_cause    <= c_CAUSE_NONE;
         r_bp_skip  <= 1'b0;
         r_halted   <= !BOOT_RUN;
      end else begin
         r_state    <= w_state_nxt;
         r_step_cnt <= w_step_cnt_nxt;
         r_cause    <= w_cause_nxt;
         r_bp_skip  <= w_bp_skip_nxt;
         r_halted   <= (w_state_nxt == ST_HALT);
      end
   end

   assign halted     = r_halted;
   assign run_state  = r_state;
   assign halt_cause = r_cause;

`ifdef PLCTRL_PERF_CNT_EN
   pl_perf_cnt #(.CNTW(CNTW)) u_perf_cnt (
      .clk       (clk),
      .rst       (rstn),
      .clr       (w_clr),
      .cyc_inc   (r_state != ST_HALT),
      .ret_inc   (retire),
      .cycle_cnt (cycle_cnt),
      .instret   (instret)
   );
`else
   // Counters absent: CLRCNT is still accepted but has nothing to clear.
   logic w_perf_unused;
   assign w_perf_unused = w_clr ^ retire;
   assign cycle_cnt     = '0;
   assign instret       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pl_run_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pl_run_ctrl
// Brief    : Directed self-checking bench for pl_run_ctrl (BOOT_RUN=1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pl_run_ctrl;

`ifdef PLCTRL_PERF_CNT_EN
   localparam bit c_PERF = 1'b1;
`else
   localparam bit c_PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] if_pc, bp_addr;
   logic        pipe_hold, retire, pipe_empty, bp_en;
   logic        fetch_stall, halted;
   logic [1:0]  run_state, halt_cause;
   logic [31:0] cycle_cnt, instret;

   int n_pass  = 0;
   int n_total = 0;
   int fires;

   pl_run_ctrl_if cmd ();

   pl_run_ctrl #(.XLEN(32), .CNTW(32), .BOOT_RUN(1'b1)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .cmd         (cmd),
      .if_pc       (if_pc),
      .pipe_hold   (pipe_hold),
      .retire      (retire),
      .pipe_empty  (pipe_empty),
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .fetch_stall (fetch_stall),
      .halted      (halted),
      .run_state   (run_state),
      .halt_cause  (halt_cause),
      .cycle_cnt   (cycle_cnt),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] steps);
      cmd.cmd_valid = 1'b1;
      cmd.cmd_op    = op;
      cmd.cmd_steps = steps;
      tick();
      cmd.cmd_valid = 1'b0;
   endtask

   // Counts cycles in STEP where IF actually advances; bounded at 20 cycles.
   task automatic run_step(input bit with_hold, output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         pipe_hold = with_hold && (i == 1 || i == 2);
         #1;
         if (run_state == 2'd1 && !fetch_stall && !pipe_hold) n++;
         @(posedge clk);
         #1;
         if (run_state != 2'd1) break;
      end
      pipe_hold = 1'b0;
   endtask

   initial begin
      rstn = 1'b1; if_pc = 32'h0; bp_addr = 32'h10; pipe_hold = 1'b0;
      retire = 1'b0; pipe_empty = 1'b1; bp_en = 1'b0;
      cmd.cmd_valid = 1'b0; cmd.cmd_op = 2'b00; cmd.cmd_steps = 8'd0;
      tick(); tick();
      check("rst_state",  run_state, 2'd0);
      check("rst_halted", halted, 1'b0);
      check("rst_cause",  halt_cause, 2'd0);
      check("rst_cycle",  cycle_cnt, 32'd0);
      rstn = 1'b0;

      // 20 running cycles with a retire every cycle
      retire = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      retire = 1'b0;
      check("run_state",   run_state, 2'd0);
      check("run_stall",   fetch_stall, 1'b0);
      check("run_halted",  halted, 1'b0);
      check("run_cycle",   cycle_cnt, c_PERF ? 32'd20 : 32'd0);
      check("run_instret", instret,   c_PERF ? 32'd20 : 32'd0);

      // Breakpoint at 0x10: same-cycle stall, drain 3 cycles, HALT on 4th edge
      bp_en = 1'b1; if_pc = 32'h0C; #1;
      check("bp_pre_stall", fetch_stall, 1'b0);
      if_pc = 32'h10; #1;
      check("bp_stall", fetch_stall, 1'b1);
      pipe_empty = 1'b0;
      tick();
      check("bp_drain", run_state, 2'd2);
      tick(); tick(); tick();
      check("bp_still_drain", run_state, 2'd2);
      check("bp_drain_halted", halted, 1'b0);
      pipe_empty = 1'b1;
      tick();
      check("bp_halt",   run_state, 2'd3);
      check("bp_halted", halted, 1'b1);
      check("bp_cause",  halt_cause, 2'd2);
      check("halt_ready", cmd.cmd_ready, 1'b1);

      // Resume at the breakpoint PC: executed once, no re-trigger
      send(2'b00, 8'd0);
      check("resume_state",  run_state, 2'd0);
      check("resume_halted", halted, 1'b0);
      check("resume_stall",  fetch_stall, 1'b0);
      check("resume_cause",  halt_cause, 2'd0);
      tick();
      if_pc = 32'h14; #1;
      check("resume_next", fetch_stall, 1'b0);
      if_pc = 32'h10; #1;
      check("bp_rearmed", fetch_stall, 1'b1);
      bp_en = 1'b0; if_pc = 32'h18; #1;

      // HALT command with an empty pipe still spends one cycle in DRAIN
      send(2'b01, 8'd0);
      check("hcmd_drain", run_state, 2'd2);
      check("drain_ready", cmd.cmd_ready, 1'b0);
      tick();
      check("hcmd_halt",  run_state, 2'd3);
      check("hcmd_cause", halt_cause, 2'd1);

      // STEP 3 with two held cycles in the middle
      send(2'b10, 8'd3);
      check("step_state", run_state, 2'd1);
      check("step_ready", cmd.cmd_ready, 1'b0);
      run_step(1'b1, fires);
      check("step3_fires", fires, 3);
      check("step3_drain", run_state, 2'd2);
      tick();
      check("step3_halt",  run_state, 2'd3);
      check("step3_cause", halt_cause, 2'd3);

      // STEP 0 behaves as STEP 1
      send(2'b10, 8'd0);
      run_step(1'b0, fires);
      check("step0_fires", fires, 1);
      tick();
      check("step0_halt", run_state, 2'd3);

      // HALT command and breakpoint in the same RUN cycle
      send(2'b00, 8'd0);
      bp_en = 1'b1; if_pc = 32'h20;
      tick();
      if_pc = 32'h10; pipe_empty = 1'b0;
      cmd.cmd_valid = 1'b1; cmd.cmd_op = 2'b01;
      tick();
      check("both_drain", run_state, 2'd2);
      check("both_ready0", cmd.cmd_ready, 1'b0);
      tick();
      check("both_ready1", cmd.cmd_ready, 1'b0);
      pipe_empty = 1'b1;
      tick();
      check("both_halt",  run_state, 2'd3);
      check("both_cause", halt_cause, 2'd2);
      tick();
      check("halt_noop", run_state, 2'd3);
      cmd.cmd_valid = 1'b0; bp_en = 1'b0;

      // CLRCNT beats a simultaneous retire
      retire = 1'b1;
      send(2'b11, 8'd0);
      check("clr_cycle",   cycle_cnt, 32'd0);
      check("clr_instret", instret, 32'd0);
      check("clr_state",   run_state, 2'd3);
      tick();
      retire = 1'b0;
      check("post_clr_instret", instret, c_PERF ? 32'd1 : 32'd0);
      check("halt_cycle_frozen", cycle_cnt, 32'd0);

      // Reset while stepping with steps remaining
      pipe_hold = 1'b1;
      send(2'b10, 8'd5);
      check("rst_step_state", run_state, 2'd1);
      rstn = 1'b1;
      tick();
      rstn = 1'b0; pipe_hold = 1'b0;
      check("rst2_state",   run_state, 2'd0);
      check("rst2_cause",   halt_cause, 2'd0);
      check("rst2_halted",  halted, 1'b0);
      check("rst2_instret", instret, 32'd0);
      check("rst2_cycle",   cycle_cnt, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
